register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Clocking SHALL use one clock and a synchronous, active-high reset, with ports clk_in and rst_in.
REQ-002 Parameter XLEN, default 32: register data width.
REQ-003 Parameter ROB_ID_W, default 5: ROB tag width; tag 0 = no dependency.
REQ-004 Parameter REG_NUM, default 32: architectural register count.
REQ-005 Ports SHALL be:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  pause when low
- _clear  in  1  mispredict flush from ROB
- _rf_launch_ready  in  1  rename rd at issue
- _rf_launch_rob_id  in  5  ROB tag of issuing instr
- _rf_launch_register_id  in  5  rd of issuing instr
- _rf_commit_ready  in  1  architectural write at commit
- _rf_commit_rob_id  in  5  ROB tag of committing instr
- _rf_commit_register_id  in  5  rd of committing instr
- _rf_commit_value  in  32  result to write
- _ask_rd_1 / _ask_rd_2  in  5 each  source register queries
- _dep_rd_1 / _dep_rd_2  out  5 each  pending ROB tag, 0 if none
- _dep_value_1 / _dep_value_2  out  32 each  architectural value

Function
REQ-006 State SHALL be value[0..31] (XLEN) and dep[0..31] (ROB_ID_W); x0 is hard-wired: value[0]=0, dep[0]=0, writes ignored.
REQ-007 Reads SHALL be combinational, zero latency: _dep_rd_n=dep[_ask_rd_n], _dep_value_n=value[_ask_rd_n].
REQ-008 Read bypass: if _rf_commit_ready && rdy_in && ask==commit rd!=0 && dep[ask]==_rf_commit_rob_id, output dep 0 and value _rf_commit_value.
REQ-009 A same-cycle launch SHALL NOT affect reads (rs==rd of the issuing instruction sees the prior tag).
REQ-010 Launch (rdy_in, no _clear, rd!=0): dep[rd]<=_rf_launch_rob_id at the next edge.
REQ-011 Commit (rdy_in, rd!=0): value[rd]<=_rf_commit_value; dep[rd]<=0 only if dep[rd]==_rf_commit_rob_id.
REQ-012 Launch and commit to the same rd in one cycle: value written, dep takes launch tag (launch wins).
REQ-013 Commit with a non-matching tag (newer rename outstanding) SHALL write value and leave dep unchanged.
REQ-014 _clear && rdy_in: all dep<=0; a same-cycle commit still writes value; a same-cycle launch is dropped.
REQ-015 rdy_in low: no state change; reads remain live.
REQ-016 Tag wrap (31->1) needs no special handling; tag 0 is never launched.

Reset
REQ-017 rst_in at a clock edge: all value and dep <=0; reset overrides rdy_in, _clear, launch, and commit.
REQ-018 After reset, every read SHALL return dep 0, value 0.

Structure
REQ-019 XLEN, ROB_ID_W, REG_NUM and the NO_DEP=0 constant SHALL live in the shared CPU package.
REQ-020 Implementation SHALL be flat with no sub-module; bypass logic is a per-port function duplicated for both query ports.

Verification
REQ-021 Reset, then query x5 -> dep 0, value 0; launch x0 tag 3 -> x0 still dep 0.
REQ-022 Launch x5 tag 4; next cycle commit x5 tag 4 value 0x1234 while asking x5 -> same cycle dep 0, value 0x1234; next cycle dep 0, value 0x1234.
REQ-023 Launch x7 tag 2, then launch x7 tag 6, then commit x7 tag 2 value 9 -> value[7]=9, dep[7]=6.
REQ-024 Same cycle launch x8 tag 10 and commit x8 tag 10 value 0xAA -> value[8]=0xAA, dep[8]=10.
REQ-025 Deps on x1..x31 pending, then _clear with commit x3 value 7 and launch x4 tag 5 -> all deps 0, value[3]=7, dep[4]=0.
REQ-026 rdy_in low during launch x9 tag 1 -> dep[9] unchanged; with rdy_in high, reset pulsed mid-stream -> all state 0.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared CPU constants: data width, ROB tag width, register count and the "no dependency" tag.
package register_file_pkg;

  localparam int XLEN     = 32;
  localparam int ROB_ID_W = 5;
  localparam int REG_NUM  = 32;
  localparam int REG_ID_W = $clog2(REG_NUM);

  localparam logic [ROB_ID_W-1:0] NO_DEP = '0;

endpackage

// File: rtl/register_file.sv
// Architectural register file with rename tags; zero-latency reads with commit bypass.
// Launch renames rd, commit writes value and clears the tag only if it still matches; x0 is fixed.
module register_file
  import register_file_pkg::*;
#(
  parameter int XLEN     = register_file_pkg::XLEN,
  parameter int ROB_ID_W = register_file_pkg::ROB_ID_W,
  parameter int REG_NUM  = register_file_pkg::REG_NUM
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       _clear,
  input  logic                       _rf_launch_ready,
  input  logic [ROB_ID_W-1:0]        _rf_launch_rob_id,
  input  logic [$clog2(REG_NUM)-1:0] _rf_launch_register_id,
  input  logic                       _rf_commit_ready,
  input  logic [ROB_ID_W-1:0]        _rf_commit_rob_id,
  input  logic [$clog2(REG_NUM)-1:0] _rf_commit_register_id,
  input  logic [XLEN-1:0]            _rf_commit_value,
  input  logic [$clog2(REG_NUM)-1:0] _ask_rd_1,
  input  logic [$clog2(REG_NUM)-1:0] _ask_rd_2,
  output logic [ROB_ID_W-1:0]        _dep_rd_1,
  output logic [ROB_ID_W-1:0]        _dep_rd_2,
  output logic [XLEN-1:0]            _dep_value_1,
  output logic [XLEN-1:0]            _dep_value_2
);

  localparam int REG_W = $clog2(REG_NUM);

  logic [XLEN-1:0]     value_q [REG_NUM];
  logic [XLEN-1:0]     value_d [REG_NUM];
  logic [ROB_ID_W-1:0] dep_q   [REG_NUM];
  logic [ROB_ID_W-1:0] dep_d   [REG_NUM];

  logic commit_fire;
  logic commit_wr;
  logic launch_wr;

  assign commit_fire = _rf_commit_ready && rdy_in;
  assign commit_wr   = commit_fire && (_rf_commit_register_id != '0);
  assign launch_wr   = _rf_launch_ready && rdy_in && !_clear && (_rf_launch_register_id != '0);

  // A commit whose tag still owns the register forwards its result and reports no dependency.
  function automatic void read_port(
    input  logic [REG_W-1:0]    ask,
    input  logic [ROB_ID_W-1:0] dep,
    input  logic [XLEN-1:0]     val,
    input  logic                fire,
    input  logic [REG_W-1:0]    c_rd,
    input  logic [ROB_ID_W-1:0] c_tag,
    input  logic [XLEN-1:0]     c_val,
    output logic [ROB_ID_W-1:0] dep_o,
    output logic [XLEN-1:0]     val_o
  );
    if (ask == '0) begin
      dep_o = NO_DEP;
      val_o = '0;
    end else if (fire && (ask == c_rd) && (dep == c_tag)) begin
      dep_o = NO_DEP;
      val_o = c_val;
    end else begin
      dep_o = dep;
      val_o = val;
    end
  endfunction

  always_comb begin
    read_port(_ask_rd_1, dep_q[_ask_rd_1], value_q[_ask_rd_1], commit_fire,
              _rf_commit_register_id, _rf_commit_rob_id, _rf_commit_value,
              _dep_rd_1, _dep_value_1);
    read_port(_ask_rd_2, dep_q[_ask_rd_2], value_q[_ask_rd_2], commit_fire,
              _rf_commit_register_id, _rf_commit_rob_id, _rf_commit_value,
              _dep_rd_2, _dep_value_2);
  end

  // Order matters: clear, then commit, then launch, so a same-rd launch overrides the commit's clear.
  always_comb begin
    value_d = value_q;
    dep_d   = dep_q;
    if (rdy_in && _clear) begin
      for (int i = 0; i < REG_NUM; i++) dep_d[i] = NO_DEP;
    end
    if (commit_wr) begin
      value_d[_rf_commit_register_id] = _rf_commit_value;
      if (dep_q[_rf_commit_register_id] == _rf_commit_rob_id)
        dep_d[_rf_commit_register_id] = NO_DEP;
    end
    if (launch_wr) dep_d[_rf_launch_register_id] = _rf_launch_rob_id;
    value_d[0] = '0;
    dep_d[0]   = NO_DEP;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        value_q[i] <= '0;
        dep_q[i]   <= NO_DEP;
      end
    end else begin
      value_q <= value_d;
      dep_q   <= dep_d;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: table of per-cycle vectors plus clear/reset sequences, scoreboard-checked.
module tb_register_file;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, _clear;
  logic        _rf_launch_ready, _rf_commit_ready;
  logic [4:0]  _rf_launch_rob_id, _rf_launch_register_id;
  logic [4:0]  _rf_commit_rob_id, _rf_commit_register_id;
  logic [31:0] _rf_commit_value;
  logic [4:0]  _ask_rd_1, _ask_rd_2, _dep_rd_1, _dep_rd_2;
  logic [31:0] _dep_value_1, _dep_value_2;

  register_file dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(_clear),
    ._rf_launch_ready(_rf_launch_ready), ._rf_launch_rob_id(_rf_launch_rob_id),
    ._rf_launch_register_id(_rf_launch_register_id),
    ._rf_commit_ready(_rf_commit_ready), ._rf_commit_rob_id(_rf_commit_rob_id),
    ._rf_commit_register_id(_rf_commit_register_id), ._rf_commit_value(_rf_commit_value),
    ._ask_rd_1(_ask_rd_1), ._ask_rd_2(_ask_rd_2),
    ._dep_rd_1(_dep_rd_1), ._dep_rd_2(_dep_rd_2),
    ._dep_value_1(_dep_value_1), ._dep_value_2(_dep_value_2)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rst, rdy, clr;
    logic        l_en;
    logic [4:0]  l_tag, l_rd;
    logic        c_en;
    logic [4:0]  c_tag, c_rd;
    logic [31:0] c_val;
    logic [4:0]  a1, a2;
    logic [4:0]  e_dep1;
    logic [31:0] e_val1;
    logic [4:0]  e_dep2;
    logic [31:0] e_val2;
  } vec_t;

  typedef struct {
    logic [4:0]  dep1;
    logic [31:0] val1;
    logic [4:0]  dep2;
    logic [31:0] val2;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(int rdy, int clr, int l_en, int l_tag, int l_rd,
                              int c_en, int c_tag, int c_rd, int c_val,
                              int a1, int a2, int ed1, int ev1, int ed2, int ev2);
    vec_t v;
    v.rst = 1'b0;           v.rdy = 1'(rdy);       v.clr = 1'(clr);
    v.l_en = 1'(l_en);      v.l_tag = 5'(l_tag);   v.l_rd = 5'(l_rd);
    v.c_en = 1'(c_en);      v.c_tag = 5'(c_tag);   v.c_rd = 5'(c_rd);
    v.c_val = 32'(c_val);   v.a1 = 5'(a1);         v.a2 = 5'(a2);
    v.e_dep1 = 5'(ed1);     v.e_val1 = 32'(ev1);
    v.e_dep2 = 5'(ed2);     v.e_val2 = 32'(ev2);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, check combinational reads mid-cycle.
  task automatic run(input vec_t v, input string nm);
    exp_t e;
    exp_t got;
    @(posedge clk_in); #1;
    rst_in = v.rst;  rdy_in = v.rdy;  _clear = v.clr;
    _rf_launch_ready = v.l_en;  _rf_launch_rob_id = v.l_tag;  _rf_launch_register_id = v.l_rd;
    _rf_commit_ready = v.c_en;  _rf_commit_rob_id = v.c_tag;  _rf_commit_register_id = v.c_rd;
    _rf_commit_value = v.c_val; _ask_rd_1 = v.a1;  _ask_rd_2 = v.a2;
    e.dep1 = v.e_dep1; e.val1 = v.e_val1; e.dep2 = v.e_dep2; e.val2 = v.e_val2;
    sb.push_back(e);
    @(negedge clk_in);
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      got = sb.pop_front();
      chk({nm, ".dep1"}, 32'(_dep_rd_1), 32'(got.dep1));
      chk({nm, ".val1"}, _dep_value_1, got.val1);
      chk({nm, ".dep2"}, 32'(_dep_rd_2), 32'(got.dep2));
      chk({nm, ".val2"}, _dep_value_2, got.val2);
    end
  endtask

  function automatic int known_val(int r);
    case (r)
      5: return 32'h1234;
      7: return 9;
      8: return 32'h88;
      default: return 0;
    endcase
  endfunction

  vec_t tbl[21];
  vec_t v;

  initial begin
    //            rdy clr l_en l_tag l_rd c_en c_tag c_rd c_val   a1 a2 ed1 ev1      ed2 ev2
    tbl[0]  = mk(1, 0, 0, 0,  0, 0, 0,  0, 0,       5, 0, 0,  0,       0,  0);
    tbl[1]  = mk(1, 0, 1, 3,  0, 0, 0,  0, 0,       0, 5, 0,  0,       0,  0);
    tbl[2]  = mk(1, 0, 0, 0,  0, 0, 0,  0, 0,       0, 5, 0,  0,       0,  0);
    tbl[3]  = mk(1, 0, 1, 4,  5, 0, 0,  0, 0,       5, 0, 0,  0,       0,  0);
    tbl[4]  = mk(1, 0, 0, 0,  0, 1, 4,  5, 'h1234,  5, 5, 0,  'h1234,  0,  'h1234);
    tbl[5]  = mk(1, 0, 0, 0,  0, 0, 0,  0, 0,       5, 7, 0,  'h1234,  0,  0);
    tbl[6]  = mk(1, 0, 1, 2,  7, 0, 0,  0, 0,       7, 0, 0,  0,       0,  0);
    tbl[7]  = mk(1, 0, 1, 6,  7, 0, 0,  0, 0,       7, 0, 2,  0,       0,  0);
    tbl[8]  = mk(1, 0, 0, 0,  0, 1, 2,  7, 9,       7, 0, 6,  0,       0,  0);
    tbl[9]  = mk(1, 0, 0, 0,  0, 0, 0,  0, 0,       7, 8, 6,  9,       0,  0);
    tbl[10] = mk(1, 0, 1, 10, 8, 1, 10, 8, 'hAA,    8, 0, 0,  0,       0,  0);
    tbl[11] = mk(1, 0, 0, 0,  0, 0, 0,  0, 0,       8, 5, 10, 'hAA,    0,  'h1234);
    tbl[12] = mk(0, 0, 1, 1,  9, 0, 0,  0, 0,       9, 0, 0,  0,       0,  0);
    tbl[13] = mk(1, 0, 0, 0,  0, 0, 0,  0, 0,       9, 0, 0,  0,       0,  0);
    tbl[14] = mk(0, 0, 0, 0,  0, 1, 10, 8, 'h55,    8, 0, 10, 'hAA,    0,  0);
    tbl[15] = mk(1, 0, 0, 0,  0, 1, 3,  8, 'h77,    8, 0, 10, 'hAA,    0,  0);
    tbl[16] = mk(1, 0, 0, 0,  0, 0, 0,  0, 0,       8, 0, 10, 'h77,    0,  0);
    tbl[17] = mk(1, 0, 0, 0,  0, 1, 10, 8, 'h88,    7, 8, 6,  9,       0,  'h88);
    tbl[18] = mk(1, 0, 0, 0,  0, 0, 0,  0, 0,       8, 7, 0,  'h88,    6,  9);
    tbl[19] = mk(1, 0, 0, 0,  0, 1, 0,  0, 'hFF,    0, 8, 0,  0,       0,  'h88);
    tbl[20] = mk(1, 0, 0, 0,  0, 0, 0,  0, 0,       0, 9, 0,  0,       0,  0);

    rst_in = 1'b1; rdy_in = 1'b1; _clear = 1'b0;
    _rf_launch_ready = 1'b0; _rf_launch_rob_id = '0; _rf_launch_register_id = '0;
    _rf_commit_ready = 1'b0; _rf_commit_rob_id = '0; _rf_commit_register_id = '0;
    _rf_commit_value = '0; _ask_rd_1 = '0; _ask_rd_2 = '0;
    repeat (2) @(posedge clk_in);

    for (int i = 0; i < 21; i++) run(tbl[i], $sformatf("row%0d", i));

    // Rename every register x1..x31 with tag equal to its index, then verify.
    for (int r = 1; r < 32; r++)
      run(mk(1, 0, 1, r, r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), $sformatf("ren%0d", r));
    for (int r = 1; r < 32; r++)
      run(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, r, 0, r, known_val(r), 0, 0), $sformatf("pend%0d", r));

    // Flush with a same-cycle commit to x3 and launch to x4.
    run(mk(1, 1, 1, 5, 4, 1, 3, 3, 7, 3, 4, 0, 7, 4, 0), "clear");
    for (int r = 1; r < 32; r++)
      run(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, r, 0, 0, (r == 3) ? 7 : known_val(r), 0, 0),
          $sformatf("post_clr%0d", r));

    // Reset pulsed alongside a launch and commit; reads stay live that cycle.
    run(mk(1, 0, 1, 12, 10, 0, 0, 0, 0, 10, 0, 0, 0, 0, 0), "pre_rst");
    v = mk(1, 1, 1, 9, 11, 1, 12, 10, 'h5A5A, 5, 10, 0, 'h1234, 0, 'h5A5A);
    v.rst = 1'b1;
    run(v, "rst_cycle");
    for (int r = 0; r < 32; r += 2)
      run(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, r, r + 1, 0, 0, 0, 0), $sformatf("post_rst%0d", r));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
